// File: rtl/sha2_msg_rx.sv
// SHA-256 message receiver/padder: packs 32-bit words into 512-bit blocks and appends FIPS 180-4 padding.
// Optional protocol checker (byte count / byte-enable legality) enabled by defining SHA2_MSG_RX_CHK_EN.
module sha2_msg_rx (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start_p,
  input  logic [63:0]  i_msg_len,
  input  logic         i_msg_vld,
  output logic         o_msg_rdy,
  input  logic [31:0]  i_msg_dat,
  input  logic [3:0]   i_msg_be,
  input  logic         i_msg_lst,
  output logic         o_blk_vld,
  input  logic         i_blk_rdy,
  output logic [511:0] o_blk_dat,
  output logic         o_blk_lst,
  output logic         o_busy,
  output logic         o_err
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PAD, S_LEN, S_EMIT} state_t;

  state_t      r_state, w_nxt;
  logic [31:0] r_buf [16];
  logic [3:0]  r_wptr;
  logic [63:0] r_len;
  logic        r_pad_pend, r_nxt_pad, r_blk_lst;
  logic        w_acc, w_pad_len, w_found;
  logic [31:0] w_mask, w_mark, w_word;

  assign w_acc     = (r_state == S_LOAD) && i_msg_vld;
  assign w_pad_len = (r_state == S_PAD) && (r_wptr == 4'd14) && !r_pad_pend;

  // Disabled bytes are zeroed; on the last word the 0x80 marker goes in the first disabled byte.
  always_comb begin
    w_mark  = '0;
    w_found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!i_msg_be[i] && !w_found) begin
        w_mark[8*i+7] = 1'b1;
        w_found       = 1'b1;
      end
    end
    w_mask = {{8{i_msg_be[3]}}, {8{i_msg_be[2]}}, {8{i_msg_be[1]}}, {8{i_msg_be[0]}}};
    w_word = (i_msg_dat & w_mask) | (i_msg_lst ? w_mark : 32'd0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    if (i_start_p) begin
      w_nxt = (i_msg_len == 64'd0) ? S_PAD : S_LOAD;
    end else begin
      case (r_state)
        S_LOAD: if (w_acc) begin
          if (r_wptr == 4'd15) w_nxt = S_EMIT;
          else if (i_msg_lst)  w_nxt = S_PAD;
        end
        S_PAD:  if (w_pad_len)            w_nxt = S_LEN;
                else if (r_wptr == 4'd15) w_nxt = S_EMIT;
        S_LEN:  w_nxt = S_EMIT;
        S_EMIT: if (i_blk_rdy) w_nxt = r_blk_lst ? S_IDLE : (r_nxt_pad ? S_PAD : S_LOAD);
        default: w_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_start_p) begin
      for (int i = 0; i < 16; i++) r_buf[i] <= '0;
      r_wptr     <= '0;
      r_len      <= i_rst_n ? i_msg_len : 64'd0;
      r_pad_pend <= i_rst_n && (i_msg_len == 64'd0);
      r_nxt_pad  <= 1'b0;
      r_blk_lst  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: if (w_acc) begin
          r_buf[r_wptr] <= w_word;
          r_wptr        <= r_wptr + 4'd1;
          if (i_msg_lst && i_msg_be == 4'b1111) r_pad_pend <= 1'b1;
          if (r_wptr == 4'd15) begin
            r_nxt_pad <= i_msg_lst;
            r_blk_lst <= 1'b0;
          end
        end
        S_PAD: if (!w_pad_len) begin
          r_buf[r_wptr] <= r_pad_pend ? 32'h8000_0000 : 32'd0;
          r_pad_pend    <= 1'b0;
          r_wptr        <= r_wptr + 4'd1;
          if (r_wptr == 4'd15) begin
            r_nxt_pad <= 1'b1;
            r_blk_lst <= 1'b0;
          end
        end
        S_LEN: begin
          r_buf[14]  <= r_len[63:32];
          r_buf[15]  <= r_len[31:0];
          r_blk_lst  <= 1'b1;
        end
        S_EMIT: if (i_blk_rdy && !r_blk_lst) begin
          for (int i = 0; i < 16; i++) r_buf[i] <= '0;
          r_wptr <= '0;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_dat
    assign o_blk_dat[511-32*g -: 32] = r_buf[g];
  end

  assign o_msg_rdy = (r_state == S_LOAD);
  assign o_blk_vld = (r_state == S_EMIT);
  assign o_blk_lst = (r_state == S_EMIT) && r_blk_lst;
  assign o_busy    = (r_state != S_IDLE);

`ifdef SHA2_MSG_RX_CHK_EN
  logic [60:0] r_bcnt, w_bsum;
  logic [2:0]  w_nb;
  logic        r_err, w_be_ok, w_bad;

  assign w_nb    = {2'b0, i_msg_be[3]} + {2'b0, i_msg_be[2]} + {2'b0, i_msg_be[1]} + {2'b0, i_msg_be[0]};
  assign w_bsum  = r_bcnt + {58'd0, w_nb};
  assign w_be_ok = (i_msg_be == 4'b1111) || (i_msg_be == 4'b1110) ||
                   (i_msg_be == 4'b1100) || (i_msg_be == 4'b1000);
  assign w_bad   = (i_msg_lst && w_bsum != r_len[63:3]) || (!i_msg_lst && w_bsum == r_len[63:3]) ||
                   !w_be_ok || (i_msg_be != 4'b1111 && !i_msg_lst);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_start_p) begin
      r_bcnt <= '0;
      r_err  <= 1'b0;
    end else if (w_acc) begin
      r_bcnt <= w_bsum;
      if (w_bad) r_err <= 1'b1;
    end
  end
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif
endmodule

// File: doc/sha2_msg_rx.md
# sha2_msg_rx

SHA-256 message receiver and padder on the DUT side of the SHA2 message stream. It accepts the word-serial message interface (start_p / msg_len / msg_vld / msg_rdy / msg_dat / msg_be / msg_lst) and assembles 32-bit words into 512-bit blocks. It appends the FIPS 180-4 padding (0x80 marker, zero fill, 64-bit big-endian bit length) and hands complete blocks to the compression core over a valid/ready handshake, flagging the final block of each message.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- start_p  in  1  one-cycle start pulse; msg_len sampled in the same cycle.
- msg_len  in  64  message length in bits; a multiple of 8.
- msg_vld  in  1  word valid.
- msg_rdy  out  1  word accepted when msg_vld && msg_rdy.
- msg_dat  in  32  message word; [31:24] is the first byte.
- msg_be  in  4  byte enables, MSB-first; only 1111, 1110, 1100 or 1000 are legal.
- msg_lst  in  1  last word of the message.
- blk_vld  out  1  512-bit block valid.
- blk_rdy  in  1  core accepts the block when blk_vld && blk_rdy.
- blk_dat  out  512  block; [511:480] is word 0, [31:0] is word 15.
- blk_lst  out  1  qualifies blk_vld; final block of the message.
- busy  out  1  state != IDLE.
- err  out  1  sticky protocol error (see Configuration).

## Operation
- Internal state: 16×32 buffer, 4-bit word pointer wptr, len_q[63:0], pad_pend flag, nxt_pad flag.
- IDLE: msg_rdy=0. On start_p:
  - len_q <= msg_len; buffer <= 0; wptr <= 0.
  - msg_len==0: pad_pend <= 1, go to PAD.
  - Otherwise go to LOAD.
- LOAD: msg_rdy=1. On accept, buffer[wptr] <= msg_dat with disabled bytes zeroed.
  - Not msg_lst: wptr++.
  - msg_lst with be!=1111: 0x80 is written into the first disabled byte of the same word.
  - msg_lst with be==1111: pad_pend <= 1.
  - msg_lst: go to PAD after wptr++.
  - Accept at wptr==15: go to EMIT (blk_lst=0). nxt_pad records whether msg_lst was set.
- PAD: one word per cycle.
  - wptr==14 && !pad_pend: go to LEN.
  - Otherwise buffer[wptr] <= pad_pend ? 0x80000000 : 0; pad_pend <= 0; wptr++.
  - Write at wptr==15: go to EMIT (blk_lst=0, nxt_pad=1).
- LEN: buffer[14] <= len_q[63:32]; buffer[15] <= len_q[31:0]; go to EMIT (blk_lst=1).
- EMIT: blk_vld=1; blk_dat and blk_lst held stable. On blk_rdy:
  - blk_lst=1: go to IDLE.
  - Otherwise buffer <= 0; wptr <= 0; go to PAD if nxt_pad, else LOAD.
- Boundaries:
  - Last full word at wptr==15: pad_pend carries into the next block, so word 0 of that block = 0x80000000.
  - Marker landing in word 14 or 15: a second block is produced.
- start_p in any non-IDLE state aborts the current message. The block restarts as from IDLE in the same cycle, and blk_vld drops the next cycle.
- msg_vld outside LOAD is ignored. blk_rdy outside EMIT is ignored.

## Timing
- Reset values: msg_rdy=0, blk_vld=0, blk_dat=0, blk_lst=0, busy=0, err=0. State returns to IDLE.
- Reset mid-operation discards all buffered data with no block emitted.
- msg_rdy, blk_vld, blk_lst and busy decode from registered state only; there is no combinational input-to-output path.
- start_p → msg_rdy high the next cycle.
- 16th word accepted → blk_vld the next cycle.
- Last word at wptr=k (k≤13) → blk_vld after (13−k) PAD cycles + 1 LEN cycle + 1.
- msg_len=0: 14 PAD cycles + LEN, then blk_vld.
- Throughput: 1 word/cycle in LOAD; 1 stall cycle per block in EMIT minimum.

## Configuration
- SHA2_MSG_RX_CHK_EN defined:
  - A 61-bit accepted-byte counter is cleared on start_p.
  - err is set when:
    - msg_lst is accepted with byte count != len_q[63:3];
    - the count reaches len_q[63:3] without msg_lst;
    - msg_be is illegal;
    - msg_be!=1111 without msg_lst.
  - err is cleared only by start_p or reset. Processing continues unchanged.
- SHA2_MSG_RX_CHK_EN undefined: no counter; err tied to 0.

## Test plan
- start_p, msg_len=0 → one block: word0=0x80000000, words 1–15 = 0, blk_lst=1.
- msg_len=24, one word 0x61626300 be=1110 lst → word0=0x61626380, word15=0x00000018, others 0, blk_lst=1.
- msg_len=448, 14 full words, lst on the 14th → block 1: words 0–13 data, word14=0x80000000, word15=0, blk_lst=0. Block 2: words 0–14 = 0, word15=0x000001C0, blk_lst=1.
- msg_len=512, 16 full words → block 1: all data, blk_lst=0. Block 2: word0=0x80000000, word15=0x00000200, blk_lst=1.
- blk_rdy held low 10 cycles in EMIT → blk_vld stays 1, blk_dat stable, msg_rdy=0. Then start_p mid-message → blk_vld=0 next cycle, new message processed correctly.
- msg_len=64, msg_lst on the 1st word, be=1111:
  - macro defined: err=1 one cycle after accept, held until the next start_p;
  - macro undefined: err=0.
